mem_port_arbiter: RTL and testbench

- Shares the single unified memory port of the multicycle CPU between two requesters:
  - port 0: the CPU memory interface (instruction fetch and load/store, already muxed by IorD);
  - port 1: the debug/program loader.
- Round-robin arbitration, one outstanding transaction at a time, variable memory latency via an ack handshake.
- A watchdog converts a hung memory access into an error response so the CPU state machine never deadlocks.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_if.sv | 73 +++++++
 rtl/arb_rr2.sv | 29 ++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the two-port memory arbiter:
//   - arb_state_e : FSM encoding (IDLE / ISSUE / RESP)
//   - PORT_CPU / PORT_DBG : requester indices used by the arbiter and picker
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_e;

  // Requester indices. Port 0 is the CPU (fetch + load/store after the IorD
  // mux), port 1 is the debug/program loader.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the two requester ports and the shared memory port.
//   Requester side (m0_* / m1_*):
//     req, we, be, addr, wdata  -> arbiter
//     gnt, rvalid, rdata, err   <- arbiter
//   Memory side (mem_*):
//     mem_req, mem_we, mem_be, mem_addr, mem_wdata <- arbiter
//     mem_ack, mem_rdata                           -> arbiter
//   busy <- arbiter
//
// Handshake: a requester raises req with we/be/addr/wdata and keeps req high
// until its rvalid. gnt pulses for one cycle when the request is captured;
// rvalid pulses for one cycle when the transaction is done (reads and writes),
// with rdata and err valid in that same cycle. On the memory side mem_req is
// held with stable mem_* until a cycle with mem_ack=1; mem_rdata is valid in
// that ack cycle.
//   modport slave  : arbiter view
//   modport master : requesters + memory model view
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            m0_req;
  logic            m0_we;
  logic [DW/8-1:0] m0_be;
  logic [AW-1:0]   m0_addr;
  logic [DW-1:0]   m0_wdata;
  logic            m0_gnt;
  logic            m0_rvalid;
  logic [DW-1:0]   m0_rdata;
  logic            m0_err;

  logic            m1_req;
  logic            m1_we;
  logic [DW/8-1:0] m1_be;
  logic [AW-1:0]   m1_addr;
  logic [DW-1:0]   m1_wdata;
  logic            m1_gnt;
  logic            m1_rvalid;
  logic [DW-1:0]   m1_rdata;
  logic            m1_err;

  logic            mem_req;
  logic            mem_we;
  logic [DW/8-1:0] mem_be;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_ack;
  logic [DW-1:0]   mem_rdata;

  logic            busy;

  modport slave (
    input  m0_req, m0_we, m0_be, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_req, m1_we, m1_be, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output busy
  );

  modport master (
    output m0_req, m0_we, m0_be, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_req, m1_we, m1_be, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  busy
  );

endinterface

// File: rtl/arb_rr2.sv
// arb_rr2
//   Pure combinational two-way round-robin pick.
//   Ports:
//     req[1:0]  in   request vector (bit i = port i)
//     last_gnt  in   index of the most recently granted port
//     pick      out  index of the chosen port (meaningful when valid=1)
//     valid     out  at least one port is requesting
module arb_rr2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       pick,
  output logic       valid
);

  always_comb begin
    valid = |req;
    pick  = PORT_CPU;
    case (req)
      2'b01:   pick = PORT_CPU;
      2'b10:   pick = PORT_DBG;
      // Contention: the port that did not win last time goes next.
      2'b11:   pick = ~last_gnt;
      default: pick = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between the CPU (port 0) and the debug loader
//   (port 1). Round-robin between contenders, one transaction in flight,
//   variable memory latency via mem_ack, and a watchdog that turns a hung
//   access into an error completion after TIMEOUT cycles in ISSUE.
//   Ports:
//     clk        in   system clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     bus        -    mem_port_arbiter_if.slave (requesters + memory port + busy)
//     dbg_state  out  current FSM state
//   Timing: request sampled at edge N -> gnt and mem_req high in cycle N+1;
//   mem_ack in cycle N+1 -> rvalid in cycle N+2; back to IDLE in N+3.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
)(
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus,
  output arb_state_e         dbg_state
);

  // Wide enough to hold TIMEOUT (counter reaches it on the exit edge).
  localparam int WDW = $clog2(TIMEOUT + 1);

  arb_state_e      state_q, state_d;
  logic            last_gnt_q;
  logic            owner_q;
  logic [WDW-1:0]  wd_cnt_q;

  logic            pick;
  logic            pick_valid;
  logic            grant;
  logic            finish;
  logic            timed_out;

  logic            win_we;
  logic [DW/8-1:0] win_be;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_wdata;
  logic [DW-1:0]   resp_data;

  assign dbg_state = state_q;

  arb_rr2 u_rr (
    .req      ({bus.m1_req, bus.m0_req}),
    .last_gnt (last_gnt_q),
    .pick     (pick),
    .valid    (pick_valid)
  );

  // Winner's request fields, chosen by the picker.
  assign win_we    = (pick == PORT_DBG) ? bus.m1_we    : bus.m0_we;
  assign win_be    = (pick == PORT_DBG) ? bus.m1_be    : bus.m0_be;
  assign win_addr  = (pick == PORT_DBG) ? bus.m1_addr  : bus.m0_addr;
  assign win_wdata = (pick == PORT_DBG) ? bus.m1_wdata : bus.m0_wdata;

  // Writes and timeouts complete with rdata=0. A timeout only fires without
  // an ack, so an ack on the last watchdog cycle still returns real data.
  assign resp_data = (timed_out || bus.mem_we) ? '0 : bus.mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    finish    = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant   = 1'b1;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (bus.mem_ack) begin
          finish  = 1'b1;
          state_d = ARB_RESP;
        end else if (wd_cnt_q == WDW'(TIMEOUT - 1)) begin
          finish    = 1'b1;
          timed_out = 1'b1;
          state_d   = ARB_RESP;
        end
      end
      // Requests are deliberately not sampled here: no back-to-back grant.
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q    <= PORT_DBG;  // so port 0 wins the first contention
      owner_q       <= PORT_CPU;
      wd_cnt_q      <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.m0_gnt    <= 1'b0;
      bus.m1_gnt    <= 1'b0;
      bus.m0_rvalid <= 1'b0;
      bus.m1_rvalid <= 1'b0;
      bus.m0_rdata  <= '0;
      bus.m1_rdata  <= '0;
      bus.m0_err    <= 1'b0;
      bus.m1_err    <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.m0_gnt <= grant && (pick == PORT_CPU);
      bus.m1_gnt <= grant && (pick == PORT_DBG);

      if (grant) begin
        owner_q       <= pick;
        last_gnt_q    <= pick;
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= win_we;
        bus.mem_be    <= win_be;
        bus.mem_addr  <= win_addr;
        bus.mem_wdata <= win_wdata;
      end else if (finish) begin
        bus.mem_req   <= 1'b0;
      end

      if (state_q == ARB_ISSUE) wd_cnt_q <= wd_cnt_q + 1'b1;
      else                      wd_cnt_q <= '0;

      // Completion outputs are only non-zero in the single RESP cycle.
      bus.m0_rvalid <= finish && (owner_q == PORT_CPU);
      bus.m1_rvalid <= finish && (owner_q == PORT_DBG);
      bus.m0_rdata  <= (finish && owner_q == PORT_CPU) ? resp_data : '0;
      bus.m1_rdata  <= (finish && owner_q == PORT_DBG) ? resp_data : '0;
      bus.m0_err    <= finish && timed_out && (owner_q == PORT_CPU);
      bus.m1_err    <= finish && timed_out && (owner_q == PORT_DBG);

      bus.busy      <= (state_d != ARB_IDLE);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter (TIMEOUT=8): a vector table of single
//   transactions plus hand-written sequences for spurious ack, contention and
//   reset in the middle of a transaction.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int BW      = DW / 8;
  localparam int TIMEOUT = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  arb_state_e dbg_state;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // Scoreboard: expected {err, rdata} per completion, in issue order.
  logic [DW:0] exp_q[$];

  typedef struct {
    logic          port;
    logic          we;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            ack_dly;   // ISSUE cycle index (0-based) carrying mem_ack
    logic          drop_req;  // deassert req right after gnt
    logic [DW-1:0] mem_rd;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_req_cyc;
  } vec_t;

  vec_t vecs[6];

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_port(input logic p, input logic req, input logic we,
                            input logic [BW-1:0] be, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata);
    if (p == PORT_CPU) begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_be = be;
      bus.m0_addr = addr; bus.m0_wdata = wdata;
    end else begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_be = be;
      bus.m1_addr = addr; bus.m1_wdata = wdata;
    end
  endtask

  function automatic logic port_gnt(input logic p);
    return p ? bus.m1_gnt : bus.m0_gnt;
  endfunction
  function automatic logic port_rvalid(input logic p);
    return p ? bus.m1_rvalid : bus.m0_rvalid;
  endfunction
  function automatic logic [DW-1:0] port_rdata(input logic p);
    return p ? bus.m1_rdata : bus.m0_rdata;
  endfunction
  function automatic logic port_err(input logic p);
    return p ? bus.m1_err : bus.m0_err;
  endfunction

  task automatic reset_dut();
    rst_n = 1'b0;
    drive_port(PORT_CPU, 1'b0, 1'b0, '0, '0, '0);
    drive_port(PORT_DBG, 1'b0, 1'b0, '0, '0, '0);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One table-driven transaction: request, check latched mem_* at gnt,
  // disturb the requester inputs, ack after ack_dly, check completion.
  task automatic run_vec(input int idx, input vec_t v);
    int          cyc;
    int          req_cyc;
    logic        seen;
    logic [DW:0] exp_e;
    @(negedge clk);
    drive_port(v.port, 1'b1, v.we, v.be, v.addr, v.wdata);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!port_gnt(v.port) && cyc < 8);
    check($sformatf("v%0d.gnt", idx), port_gnt(v.port), 1);
    check($sformatf("v%0d.other_gnt", idx), port_gnt(!v.port), 0);
    check($sformatf("v%0d.mem_addr", idx), bus.mem_addr, v.addr);
    check($sformatf("v%0d.mem_we", idx), bus.mem_we, v.we);
    check($sformatf("v%0d.mem_be", idx), bus.mem_be, v.be);
    check($sformatf("v%0d.mem_wdata", idx), bus.mem_wdata, v.wdata);
    drive_port(v.port, !v.drop_req, v.we, ~v.be, ~v.addr, ~v.wdata);
    exp_q.push_back({v.exp_err, v.exp_rdata});

    req_cyc = 0;
    seen    = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.mem_req) req_cyc++;
      check($sformatf("v%0d.addr_stable", idx), bus.mem_addr, v.addr);
      bus.mem_ack   = (k == v.ack_dly);
      bus.mem_rdata = (k == v.ack_dly) ? v.mem_rd : DW'($urandom());
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (port_rvalid(v.port)) begin
        seen = 1'b1;
        break;
      end
    end
    check($sformatf("v%0d.rvalid", idx), seen, 1);
    check($sformatf("v%0d.req_cycles", idx), req_cyc, v.exp_req_cyc);
    check($sformatf("v%0d.mem_req_low", idx), bus.mem_req, 0);
    check($sformatf("v%0d.other_rvalid", idx), port_rvalid(!v.port), 0);
    check($sformatf("v%0d.other_rdata", idx), port_rdata(!v.port), 0);
    exp_e = exp_q.pop_front();
    check($sformatf("v%0d.err_rdata", idx), {port_err(v.port), port_rdata(v.port)}, exp_e);
    drive_port(v.port, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    check($sformatf("v%0d.rvalid_one_cycle", idx), port_rvalid(v.port), 0);
    check($sformatf("v%0d.busy_low", idx), bus.busy, 0);
  endtask

  // ---------------- main test ----------------
  initial begin
    logic gport[4];
    int   gcyc[4];
    logic rport[4];
    int   rcyc[4];
    logic [DW-1:0] rdat[4];
    int   ng, nr, cyc;
    logic early_rv;

    //          port      we    be       addr          wdata         dly drop mem_rd        exp_rdata     err  reqc
    vecs[0] = '{PORT_CPU, 1'b0, 4'b1111, 32'h0000_0100, 32'h0000_0055, 2,  1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3};
    vecs[1] = '{PORT_DBG, 1'b1, 4'b0011, 32'h0000_0200, 32'h1234_5678, 0,  1'b0, 32'hAAAA_5555, 32'h0000_0000, 1'b0, 1};
    vecs[2] = '{PORT_CPU, 1'b1, 4'b1100, 32'h0000_0104, 32'h0F0F_0F0F, 1,  1'b1, 32'h1111_2222, 32'h0000_0000, 1'b0, 2};
    vecs[3] = '{PORT_DBG, 1'b0, 4'b1111, 32'h0000_03FC, 32'h0000_0000, 7,  1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 8};
    vecs[4] = '{PORT_CPU, 1'b0, 4'b1111, 32'h0000_0400, 32'h0000_0000, 99, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 8};
    vecs[5] = '{PORT_DBG, 1'b0, 4'b0001, 32'h0000_0404, 32'h0000_0000, 0,  1'b1, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 1};

    // Reset state
    reset_dut();
    @(negedge clk);
    check("rst.state", dbg_state, ARB_IDLE);
    check("rst.busy", bus.busy, 0);
    check("rst.mem_req", bus.mem_req, 0);
    check("rst.mem_fields", {bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata}, 0);
    check("rst.gnt", {bus.m0_gnt, bus.m1_gnt}, 0);
    check("rst.rvalid", {bus.m0_rvalid, bus.m1_rvalid}, 0);
    check("rst.rdata_err", {bus.m0_err, bus.m1_err, bus.m0_rdata, bus.m1_rdata}, 0);

    // Spurious ack while idle is ignored
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("spur.busy", bus.busy, 0);
      check("spur.rvalid", {bus.m0_rvalid, bus.m1_rvalid}, 0);
    end
    bus.mem_ack = 1'b0;

    // Table-driven single transactions
    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Contention from reset with zero-latency memory
    reset_dut();
    @(negedge clk);
    drive_port(PORT_CPU, 1'b1, 1'b0, 4'hF, 32'h0000_1000, '0);
    drive_port(PORT_DBG, 1'b1, 1'b0, 4'hF, 32'h0000_2000, '0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5A5A_5A5A;
    ng = 0; nr = 0; cyc = 0;
    while (nr < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.m0_gnt && bus.m1_gnt) check("cont.two_gnts", 1, 0);
      if ((bus.m0_gnt || bus.m1_gnt) && ng < 4) begin
        gport[ng] = bus.m1_gnt;
        gcyc[ng]  = cyc;
        ng++;
      end
      if ((bus.m0_rvalid || bus.m1_rvalid) && nr < 4) begin
        rport[nr] = bus.m1_rvalid;
        rcyc[nr]  = cyc;
        rdat[nr]  = bus.m1_rvalid ? bus.m1_rdata : bus.m0_rdata;
        nr++;
      end
    end
    drive_port(PORT_CPU, 1'b0, 1'b0, '0, '0, '0);
    drive_port(PORT_DBG, 1'b0, 1'b0, '0, '0, '0);
    bus.mem_ack = 1'b0;
    check("cont.grants", ng, 4);
    check("cont.completions", nr, 4);
    for (int i = 0; i < ng && i < nr; i++) begin
      check($sformatf("cont.order%0d", i), gport[i], (i % 2 == 1));
      check($sformatf("cont.rv_port%0d", i), rport[i], gport[i]);
      check($sformatf("cont.rv_lat%0d", i), rcyc[i] - gcyc[i], 1);
      check($sformatf("cont.rdata%0d", i), rdat[i], 32'h5A5A_5A5A);
      if (i > 0) check($sformatf("cont.spacing%0d", i), gcyc[i] - gcyc[i-1], 3);
    end
    @(negedge clk);
    check("cont.busy_low", bus.busy, 0);

    // Reset during ISSUE: port 0 owns the port (so port 1 would be next)
    drive_port(PORT_CPU, 1'b1, 1'b0, 4'hF, 32'h0000_3000, '0);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.m0_gnt && cyc < 8);
    check("rmid.gnt", bus.m0_gnt, 1);
    repeat (2) @(negedge clk);
    check("rmid.issue_req", bus.mem_req, 1);
    check("rmid.issue_busy", bus.busy, 1);
    drive_port(PORT_DBG, 1'b1, 1'b0, 4'hF, 32'h0000_4000, '0);
    rst_n = 1'b0;
    #1;
    check("rmid.mem_req", bus.mem_req, 0);
    check("rmid.busy", bus.busy, 0);
    check("rmid.gnt0", {bus.m0_gnt, bus.m1_gnt}, 0);
    check("rmid.state", dbg_state, ARB_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    early_rv = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.m0_rvalid || bus.m1_rvalid) early_rv = 1'b1;
    end while (!(bus.m0_gnt || bus.m1_gnt) && cyc < 8);
    check("rmid.no_rvalid", early_rv, 0);
    check("rmid.winner", {bus.m1_gnt, bus.m0_gnt}, 2'b01);
    drive_port(PORT_DBG, 1'b0, 1'b0, '0, '0, '0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0000_7777;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    drive_port(PORT_CPU, 1'b0, 1'b0, '0, '0, '0);
    check("rmid.after_rvalid", bus.m0_rvalid, 1);
    check("rmid.after_rdata", bus.m0_rdata, 32'h0000_7777);
    @(negedge clk);
    check("rmid.after_busy", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1, "global timeout");
  end

endmodule
